psum_accum: RTL and testbench

Consumer end of the multiplier psum interface. Accepts a stream of packed multiplier results and accumulates a configured number of them. In 8-bit mode it forms one full-width sum; in 2x4-bit mode it forms two independent half-width lane sums. It sits between the multiplier array and the output/requantisation stage, with valid/ready handshakes on the config, input and output sides.

---
 rtl/diff_demo_pkg.sv | 13 +
 rtl/psum_accum_sat.sv | 20 ++
 rtl/psum_accum.sv | 141 ++++++++++++++
 tb/tb_psum_accum.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/diff_demo_pkg.sv
// Shared definitions for the multiplier / psum datapath.
// Holds the psum word width and the accumulator state encoding.
package diff_demo_pkg;

    localparam int PSUM_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } psum_accum_state_e;

endpackage

// File: rtl/psum_accum_sat.sv
// Combinational unsigned saturating adder of WIDTH bits.
// ovf flags that the true sum did not fit and sum was clamped to all-ones.
module sat_add #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        ovf = raw[WIDTH];
        sum = raw[WIDTH] ? {WIDTH{1'b1}} : raw[WIDTH-1:0];
    end

endmodule

// File: rtl/psum_accum.sv
// Accumulates a configured number of packed multiplier psum words, either as
// one full-width saturating sum or as two independent half-width lane sums.
module psum_accum
    import diff_demo_pkg::*;
#(
    parameter int PSUM_WIDTH = diff_demo_pkg::PSUM_WIDTH,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic                  cfg_mode,
    input  logic [CNT_WIDTH-1:0]  cfg_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PSUM_WIDTH-1:0] in_psum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PSUM_WIDTH-1:0] out_sum,
    output logic                  out_mode,
    output logic [1:0]            out_ovf,
    output logic [1:0]            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; ready depends only on state, never on the matching valid.

    localparam int HW = PSUM_WIDTH / 2;

    psum_accum_state_e     state_q, state_d;
    logic [PSUM_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic                  mode_q, mode_d;
    logic [1:0]            ovf_q, ovf_d;

    logic [HW-1:0]         lo_sum, hi_sum;
    logic                  lo_ovf, hi_ovf;
    logic [PSUM_WIDTH:0]   full_raw;
    logic [PSUM_WIDTH-1:0] full_sum;
    logic                  full_ovf;

    sat_add #(.WIDTH(HW)) u_lane_lo (
        .a   (acc_q[HW-1:0]),
        .b   (in_psum[HW-1:0]),
        .sum (lo_sum),
        .ovf (lo_ovf)
    );

    sat_add #(.WIDTH(HW)) u_lane_hi (
        .a   (acc_q[PSUM_WIDTH-1:HW]),
        .b   (in_psum[PSUM_WIDTH-1:HW]),
        .sum (hi_sum),
        .ovf (hi_ovf)
    );

    always_comb begin
        full_raw = {1'b0, acc_q} + {1'b0, in_psum};
        full_ovf = full_raw[PSUM_WIDTH];
        full_sum = full_ovf ? {PSUM_WIDTH{1'b1}} : full_raw[PSUM_WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        mode_d  = cfg_mode;
                        len_d   = (cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = '0;
                        state_d = ACC;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        // Saturated lanes stay at max: adding to all-ones clamps again.
                        if (mode_q) begin
                            acc_d = {hi_sum, lo_sum};
                            ovf_d = ovf_q | {hi_ovf, lo_ovf};
                        end else begin
                            acc_d = full_sum;
                            ovf_d = ovf_q | {1'b0, full_ovf};
                        end
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                        if (cnt_q == len_q - CNT_WIDTH'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
        end
    end

    assign cfg_ready = (state_q == IDLE);
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_mode  = mode_q;
    assign out_ovf   = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_psum_accum.sv
// Directed plus randomized checks of psum_accum against a saturating-sum
// model computed from the beat list of each configured sum.
module tb_psum_accum;

  localparam int PW = 32;
  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_mode;
  logic [CW-1:0] cfg_len;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_psum;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_sum;
  logic          out_mode;
  logic [1:0]    out_ovf;
  logic [1:0]    dbg_state;

  int vectors;
  int miscompares;

  logic [PW-1:0] beats[$];
  logic [PW-1:0] exp_q[$];
  logic [1:0]    exp_ovf_q[$];

  psum_accum #(.PSUM_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_psum   (in_psum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_mode  (out_mode),
    .out_ovf   (out_ovf),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: sum of the beat list with per-lane unsigned saturation
  task automatic model(input logic mode);
    longint unsigned s, lo, hi;
    logic [1:0] o;
    s = 0; lo = 0; hi = 0; o = 2'b00;
    foreach (beats[i]) begin
      if (!mode) begin
        s = s + longint'(beats[i]);
        if (s > 64'hFFFF_FFFF) begin
          s = 64'hFFFF_FFFF;
          o[0] = 1'b1;
        end
      end else begin
        lo = lo + longint'(beats[i][15:0]);
        hi = hi + longint'(beats[i][31:16]);
        if (lo > 65535) begin lo = 65535; o[0] = 1'b1; end
        if (hi > 65535) begin hi = 65535; o[1] = 1'b1; end
      end
    end
    if (mode) exp_q.push_back({hi[15:0], lo[15:0]});
    else      exp_q.push_back(s[31:0]);
    exp_ovf_q.push_back(o);
  endtask

  // drivers
  task automatic do_cfg(input logic mode, input logic [CW-1:0] len);
    check("cfg_ready_idle", cfg_ready, 1'b1);
    cfg_valid = 1'b1;
    cfg_mode  = mode;
    cfg_len   = len;
    tick();
    cfg_valid = 1'b0;
    cfg_mode  = $urandom_range(0, 1);
    cfg_len   = CW'($urandom);
    check("in_ready_acc", in_ready, 1'b1);
  endtask

  task automatic send_beats(input int max_gap);
    foreach (beats[i]) begin
      int gap;
      gap = $urandom_range(0, max_gap);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_psum  = $urandom;
        tick();
      end
      in_valid = 1'b1;
      in_psum  = beats[i];
      tick();
    end
    in_valid = 1'b0;
    in_psum  = $urandom;
  endtask

  // scoreboard: compare the presented result, hold under backpressure, then accept
  task automatic check_result(input logic mode, input int hold);
    logic [PW-1:0] es;
    logic [1:0]    eo;
    es = exp_q.pop_front();
    eo = exp_ovf_q.pop_front();
    check("out_valid", out_valid, 1'b1);
    check("out_sum", out_sum, es);
    check("out_ovf", out_ovf, eo);
    check("out_mode", out_mode, mode);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", out_valid, 1'b1);
      check("hold_sum", out_sum, es);
      check("hold_ovf", out_ovf, eo);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_cfg_ready", cfg_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_drop", out_valid, 1'b0);
  endtask

  task automatic run_sum(input logic mode, input logic [CW-1:0] len, input int max_gap, input int hold);
    do_cfg(mode, len);
    model(mode);
    send_beats(max_gap);
    check_result(mode, hold);
  endtask

  function automatic logic [PW-1:0] rand_word();
    case ($urandom_range(0, 2))
      0:       return PW'($urandom_range(0, 300));
      1:       return {16'($urandom_range(0, 40000)), 16'($urandom_range(0, 40000))};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic md;
    logic [PW-1:0] ref_sum;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; clr = 1'b0; cfg_valid = 1'b0; cfg_mode = 1'b0; cfg_len = '0;
    in_valid = 1'b0; in_psum = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, 32'd0);
    check("rst_out_ovf", out_ovf, 2'b00);
    check("rst_out_mode", out_mode, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);

    // mode 0, three beats of 255*255
    beats = '{32'd65025, 32'd65025, 32'd65025};
    run_sum(1'b0, 8'd3, 0, 0);

    // mode 1, lanes never carry into each other
    beats = '{32'h0014_000A, 32'h0014_000A};
    run_sum(1'b1, 8'd2, 0, 0);

    // lower lane saturation
    beats.delete();
    for (int i = 0; i < 18; i++) beats.push_back(32'h0000_0EF1);
    run_sum(1'b1, 8'd18, 0, 0);

    // full-width saturation
    beats = '{32'hFFFF_0000, 32'hFFFF_0000};
    run_sum(1'b0, 8'd2, 0, 0);

    // backpressure, then gaps give the same sum as the gap-free run
    beats = '{32'd1000, 32'd2000, 32'd3000, 32'd4000};
    run_sum(1'b0, 8'd4, 0, 5);
    run_sum(1'b0, 8'd4, 3, 2);

    // clr mid-sum with a beat offered in the same cycle
    beats = '{32'd5, 32'd6};
    do_cfg(1'b0, 8'd4);
    send_beats(0);
    clr = 1'b1; in_valid = 1'b1; in_psum = 32'd100;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    check("clr_out_valid", out_valid, 1'b0);
    check("clr_cfg_ready", cfg_ready, 1'b1);
    check("clr_in_ready", in_ready, 1'b0);
    beats = '{32'd7};
    run_sum(1'b0, 8'd1, 0, 0);

    // len 0 behaves as len 1
    beats = '{32'd9};
    run_sum(1'b0, 8'd0, 0, 0);

    // async reset mid-ACC
    beats = '{32'h1234_5678};
    do_cfg(1'b1, 8'd3);
    send_beats(0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_sum", out_sum, 32'd0);
    check("arst_out_mode", out_mode, 1'b0);
    check("arst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_cfg_ready", cfg_ready, 1'b1);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_ovf", out_ovf, 2'b00);
    check("arst_out_sum2", out_sum, 32'd0);

    // randomized sums
    for (int t = 0; t < 24; t++) begin
      md = $urandom_range(0, 1);
      n  = $urandom_range(0, 7);
      beats.delete();
      for (int i = 0; i < ((n == 0) ? 1 : n); i++) beats.push_back(rand_word());
      run_sum(md, CW'(n), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // gap-free vs gappy run of one random beat list
    beats.delete();
    for (int i = 0; i < 6; i++) beats.push_back(rand_word());
    model(1'b1);
    ref_sum = exp_q[0];
    run_sum(1'b1, 8'd6, 0, 0);
    exp_q.pop_front();
    exp_ovf_q.pop_front();
    do_cfg(1'b1, 8'd6);
    send_beats(4);
    check("gap_sum_equal", out_sum, ref_sum);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
